// File: rtl/vga_timing_pipe.sv
// VGA timing generator. It issues pixel-coordinate requests to an external
// source, re-aligns the returned data with sync through a fixed delay line,
// and provides built-in test patterns that switch only on frame boundaries.
module vga_timing_pipe #(
    parameter int   PIXEL_BITS   = 4,
    parameter int   CLK_DIV      = 2,
    parameter int   H_ACTIVE     = 640,
    parameter int   H_FP         = 16,
    parameter int   H_SYNC       = 96,
    parameter int   H_BP         = 48,
    parameter int   V_ACTIVE     = 480,
    parameter int   V_FP         = 10,
    parameter int   V_SYNC       = 2,
    parameter int   V_BP         = 33,
    parameter logic H_SYNC_POL   = 1'b0,
    parameter logic V_SYNC_POL   = 1'b0,
    parameter int   DATA_LATENCY = 2,
    parameter int   CHECK_SHIFT  = 3,
    localparam int  H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  H_BITS       = $clog2(H_TOTAL),
    localparam int  V_BITS       = $clog2(V_TOTAL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PIXEL_BITS-1:0] pix_r,
    input  logic [PIXEL_BITS-1:0] pix_g,
    input  logic [PIXEL_BITS-1:0] pix_b,
    input  logic [1:0]            pattern_sel,
    output logic                  pix_tick,
    output logic [H_BITS-1:0]     vga_x,
    output logic [V_BITS-1:0]     vga_y,
    output logic                  vga_req,
    output logic [PIXEL_BITS-1:0] vga_r,
    output logic [PIXEL_BITS-1:0] vga_g,
    output logic [PIXEL_BITS-1:0] vga_b,
    output logic                  h_sync,
    output logic                  v_sync,
    output logic                  vga_active,
    output logic                  frame_start,
    output logic                  line_start
);

    localparam int DIV_BITS = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW       = 3 * PIXEL_BITS;
    localparam int BAR_W    = H_ACTIVE / 8;

    localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(CLK_DIV - 1);
    localparam logic [H_BITS-1:0]   H_LAST   = H_BITS'(H_TOTAL - 1);
    localparam logic [H_BITS-1:0]   H_ACT    = H_BITS'(H_ACTIVE);
    localparam logic [H_BITS-1:0]   HS_START = H_BITS'(H_ACTIVE + H_FP);
    localparam logic [H_BITS-1:0]   HS_END   = H_BITS'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_BITS-1:0]   V_LAST   = V_BITS'(V_TOTAL - 1);
    localparam logic [V_BITS-1:0]   V_ACT    = V_BITS'(V_ACTIVE);
    localparam logic [V_BITS-1:0]   VS_START = V_BITS'(V_ACTIVE + V_FP);
    localparam logic [V_BITS-1:0]   VS_END   = V_BITS'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Everything the output stage needs about one requested position.
    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          req;
        logic          sol;
        logic          sof;
        logic          ext;
        logic [CW-1:0] col;
    } pipe_t;

    logic [DIV_BITS-1:0] div_q, div_d;
    logic [H_BITS-1:0]   h_cnt_q, h_cnt_d;
    logic [V_BITS-1:0]   v_cnt_q, v_cnt_d;
    logic [1:0]          pat_q;
    logic                h_last, v_last, tick;

    logic [H_BITS-1:0]   vga_x_q;
    logic [V_BITS-1:0]   vga_y_q;
    logic                vga_req_q;
    pipe_t               s0;
    pipe_t               pipe_q [DATA_LATENCY];
    pipe_t               tail;

    logic [2:0]          bar_idx;
    logic                chk;

    logic [CW-1:0]       rgb_q, rgb_d;
    logic                hs_q, vs_q, act_q, fs_q, ls_q;

    assign h_last = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);
    // Held low during reset so CLK_DIV=1 does not show a tick under reset.
    assign tick   = (div_q == DIV_LAST) && !rst;
    assign tail   = pipe_q[DATA_LATENCY-1];

    // Next-state for the clock divider and the raster counters.
    always_comb begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
    end

    // Free-running divider producing the one-clk pixel enable.
    always_ff @(posedge clk) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

    // Raster counters; the pattern is captured as the counters wrap to (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            pat_q   <= '0;
        end else if (tick) begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            if (h_last && v_last) pat_q <= pattern_sel;
        end
    end

    // Bar index by boundary comparison; anything past bar 7 stays in bar 7.
    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++)
            if (int'(h_cnt_q) >= k * BAR_W) bar_idx = 3'(k);
        chk = (|((h_cnt_q >> CHECK_SHIFT) & H_BITS'(1))) ^
              (|((v_cnt_q >> CHECK_SHIFT) & V_BITS'(1)));
    end

    // Stage-0 attributes of the position being requested this tick.
    always_comb begin
        s0     = '0;
        s0.hs  = (h_cnt_q >= HS_START) && (h_cnt_q <= HS_END);
        s0.vs  = (v_cnt_q >= VS_START) && (v_cnt_q <= VS_END);
        s0.req = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        s0.sol = (h_cnt_q == '0);
        s0.sof = (h_cnt_q == '0) && (v_cnt_q == '0);
        s0.ext = (pat_q == 2'd0);
        case (pat_q)
            2'd1:    s0.col = {{PIXEL_BITS{bar_idx[2]}}, {PIXEL_BITS{bar_idx[1]}},
                               {PIXEL_BITS{bar_idx[0]}}};
            2'd2:    s0.col = {CW{chk}};
            2'd3:    s0.col = '1;
            default: s0.col = '0;
        endcase
    end

    // Request registers plus the delay line matching the source latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_x_q   <= '0;
            vga_y_q   <= '0;
            vga_req_q <= 1'b0;
            for (int i = 0; i < DATA_LATENCY; i++) pipe_q[i] <= '0;
        end else if (tick) begin
            vga_x_q   <= h_cnt_q;
            vga_y_q   <= v_cnt_q;
            vga_req_q <= s0.req;
            pipe_q[0] <= s0;
            for (int i = 1; i < DATA_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // Colour source select for the position leaving the delay line.
    always_comb begin
        rgb_d = '0;
        if (tail.req) rgb_d = tail.ext ? {pix_r, pix_g, pix_b} : tail.col;
    end

    // Output registers; the start pulses last one clk, the rest hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
            hs_q  <= ~H_SYNC_POL;
            vs_q  <= ~V_SYNC_POL;
            act_q <= 1'b0;
            fs_q  <= 1'b0;
            ls_q  <= 1'b0;
        end else begin
            fs_q <= 1'b0;
            ls_q <= 1'b0;
            if (tick) begin
                rgb_q <= rgb_d;
                hs_q  <= tail.hs ? H_SYNC_POL : ~H_SYNC_POL;
                vs_q  <= tail.vs ? V_SYNC_POL : ~V_SYNC_POL;
                act_q <= tail.req;
                fs_q  <= tail.sof;
                ls_q  <= tail.sol;
            end
        end
    end

    assign pix_tick    = tick;
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_req     = vga_req_q;
    assign {vga_r, vga_g, vga_b} = rgb_q;
    assign h_sync      = hs_q;
    assign v_sync      = vs_q;
    assign vga_active  = act_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;

endmodule
